// File: rtl/branch_pkg.sv
// Shared encodings and the default jump-target table for the branch/control stage.
package branch_pkg;

    localparam int PC_W_DEF = 6;

    // Major opcodes handled by the branch unit (Instruction[8:6]).
    typedef enum logic [2:0] {
        OP_CTL = 3'b110,
        OP_BR  = 3'b111
    } op_e;

    // Branch conditions (Instruction[5:4] when op is OP_BR).
    typedef enum logic [1:0] {
        ALW = 2'b00,
        EQ  = 2'b01,
        NE  = 2'b10,
        LT  = 2'b11
    } cond_e;

    // Control sub-operations (Instruction[5:4] when op is OP_CTL).
    typedef enum logic [1:0] {
        LOOP = 2'b00,
        DJNZ = 2'b01,
        CALL = 2'b10,
        RETH = 2'b11
    } ctl_e;

    // Under RETH, the index field selects return or halt; anything else is a no-op.
    localparam logic [3:0] IDX_HALT = 4'hF;
    localparam logic [3:0] IDX_RET  = 4'h0;

    // Jump targets addressed by the 4-bit index field; entry i holds 4*i.
    localparam logic [PC_W_DEF-1:0] JUMP_LUT [16] = '{
        6'd0,  6'd4,  6'd8,  6'd12, 6'd16, 6'd20, 6'd24, 6'd28,
        6'd32, 6'd36, 6'd40, 6'd44, 6'd48, 6'd52, 6'd56, 6'd60
    };

endpackage

// File: rtl/branch_lut.sv
// Combinational jump-target ROM: index field -> absolute jump target.
module branch_lut
    import branch_pkg::*;
#(
    parameter int PC_W    = 6,
    parameter int LUT_IDX = 4
) (
    input  logic [LUT_IDX-1:0] idx,
    output logic [PC_W-1:0]    target
);

    // Pure table lookup, resized to the program-counter width.
    always_comb begin
        target = PC_W'(JUMP_LUT[idx]);
    end

endmodule

// File: rtl/branch_unit.sv
// Branch/control stage: decodes the fetched instruction against registered
// Z/N flags, loop counter, one-entry link register and halt state, and drives
// Jen/Jump back to the program counter in the same cycle.
module branch_unit
    import branch_pkg::*;
#(
    parameter int PC_W    = 6,
    parameter int LUT_IDX = 4,
    parameter int CNT_W   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [8:0]       Instruction,
    input  logic [PC_W-1:0]  PC,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             flag_we,
    output logic             Jen,
    output logic [PC_W-1:0]  Jump,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] loop_cnt
);

    logic [2:0]       op;
    logic [1:0]       sub;
    logic [3:0]       idx;
    logic [PC_W-1:0]  target;

    logic             flag_z;
    logic             flag_n;
    logic [PC_W-1:0]  link;
    logic             link_v;

    logic             flag_z_nxt;
    logic             flag_n_nxt;
    logic [CNT_W-1:0] loop_cnt_nxt;
    logic [PC_W-1:0]  link_nxt;
    logic             link_v_nxt;
    logic             halted_nxt;
    logic             err_nxt;

    assign op  = Instruction[8:6];
    assign sub = Instruction[5:4];
    assign idx = Instruction[3:0];

    branch_lut #(
        .PC_W    (PC_W),
        .LUT_IDX (LUT_IDX)
    ) u_lut (
        .idx    (Instruction[LUT_IDX-1:0]),
        .target (target)
    );

    // Decode: same-cycle jump request plus next values of every state register.
    always_comb begin
        Jen          = 1'b0;
        Jump         = '0;
        flag_z_nxt   = flag_z;
        flag_n_nxt   = flag_n;
        loop_cnt_nxt = loop_cnt;
        link_nxt     = link;
        link_v_nxt   = link_v;
        halted_nxt   = halted;
        err_nxt      = err;

        if (halted) begin
            // Re-jumping to the current PC keeps the fetch frozen; all state holds.
            Jen  = 1'b1;
            Jump = PC;
        end else begin
            // Flag writes land at the edge; this cycle's branch still sees the old flags.
            if (flag_we) begin
                flag_z_nxt = alu_zero;
                flag_n_nxt = alu_neg;
            end

            if (op == OP_BR) begin
                case (cond_e'(sub))
                    ALW:     Jen = 1'b1;
                    EQ:      Jen = flag_z;
                    NE:      Jen = ~flag_z;
                    LT:      Jen = flag_n;
                    default: Jen = 1'b0;
                endcase
                if (Jen) begin
                    Jump = target;
                end
            end else if (op == OP_CTL) begin
                case (ctl_e'(sub))
                    LOOP: begin
                        loop_cnt_nxt = CNT_W'(idx);
                    end
                    DJNZ: begin
                        // A zero counter saturates: no decrement, no jump.
                        if (loop_cnt != '0) begin
                            loop_cnt_nxt = loop_cnt - CNT_W'(1);
                            if (loop_cnt != CNT_W'(1)) begin
                                Jen  = 1'b1;
                                Jump = target;
                            end
                        end
                    end
                    CALL: begin
                        // Only one link entry: a nested call clobbers it and flags misuse.
                        if (link_v) begin
                            err_nxt = 1'b1;
                        end
                        link_nxt   = PC + PC_W'(1);
                        link_v_nxt = 1'b1;
                        Jen        = 1'b1;
                        Jump       = target;
                    end
                    RETH: begin
                        if (idx == IDX_RET) begin
                            if (link_v) begin
                                Jen        = 1'b1;
                                Jump       = link;
                                link_v_nxt = 1'b0;
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end else if (idx == IDX_HALT) begin
                            // The halt cycle itself does not jump; freezing starts next cycle.
                            halted_nxt = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            loop_cnt <= '0;
            link     <= '0;
            link_v   <= 1'b0;
            halted   <= 1'b0;
            err      <= 1'b0;
        end else begin
            flag_z   <= flag_z_nxt;
            flag_n   <= flag_n_nxt;
            loop_cnt <= loop_cnt_nxt;
            link     <= link_nxt;
            link_v   <= link_v_nxt;
            halted   <= halted_nxt;
            err      <= err_nxt;
        end
    end

endmodule
